// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use / MDU stall detection and
// F/D/E stall/flush generation for the pipelined RISC-V core. Also tracks
// one outstanding multi-cycle MDU operation (latency counter plus pending
// destination register).
//
// Optional build macro HAZARD_PERF_EN adds three saturating 32-bit
// performance counters (stall cycles, taken-branch cycles, MDU issues).
//
// Handshake note: this block has no valid/ready interfaces. MduStartE is a
// one-cycle issue strobe. The decode stage must not present an MDU op to E
// while StallD is high, so a second issue cannot overlap a busy MDU.
module hazard_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_SRC     = 2,
    parameter int MDU_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] RsD,
    input  logic                          MduOpD,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] RsE,
    input  logic [ADDR_WIDTH-1:0]         RdE,
    input  logic                          LoadE,
    input  logic                          MduStartE,
    input  logic                          PCSrcE,
    input  logic [ADDR_WIDTH-1:0]         RdM,
    input  logic                          RegWriteM,
    input  logic [ADDR_WIDTH-1:0]         RdW,
    input  logic                          RegWriteW,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] rdE,
    input  logic [DATA_WIDTH-1:0]         ALUResultM,
    input  logic [DATA_WIDTH-1:0]         ResultW,
    output logic [NUM_SRC*DATA_WIDTH-1:0] SrcE,
    output logic [NUM_SRC*2-1:0]          ForwardE,
    output logic                          StallF,
    output logic                          StallD,
    output logic                          FlushD,
    output logic                          FlushE,
    output logic                          MduBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                   PerfStallCnt,
    output logic [31:0]                   PerfFlushCnt,
    output logic [31:0]                   PerfMduCnt
`endif
);

    localparam int CNT_W = $clog2(MDU_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LATENCY);

    // MDU tracking state
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
    logic                  busy_q, busy_d;

    // Per-source hazard match bits
    logic [NUM_SRC-1:0] ld_hit;
    logic [NUM_SRC-1:0] pend_hit;
    logic               lw_stall;
    logic               mdu_stall;
    logic               stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_WIDTH-1:0] rs_e;
        logic [ADDR_WIDTH-1:0] rs_d;
        logic [1:0]            fwd;

        assign rs_e = RsE[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rs_d = RsD[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Forward select: MEM beats WB, and x0 is never forwarded
        always_comb begin
            fwd = 2'b00;
            if (RegWriteM && (RdM != '0) && (RdM == rs_e)) begin
                fwd = 2'b10;
            end else if (RegWriteW && (RdW != '0) && (RdW == rs_e)) begin
                fwd = 2'b01;
            end
        end

        assign ForwardE[2*i +: 2] = fwd;
        assign SrcE[i*DATA_WIDTH +: DATA_WIDTH] =
            (fwd == 2'b10) ? ALUResultM :
            (fwd == 2'b01) ? ResultW :
                             rdE[i*DATA_WIDTH +: DATA_WIDTH];

        assign ld_hit[i]   = (rs_d == RdE);
        assign pend_hit[i] = (rs_d == pend_rd_q);
    end

    // Stall and flush generation; flush priority for D/E is left to the pipeline
    always_comb begin
        lw_stall  = LoadE && (RdE != '0) && (|ld_hit);
        mdu_stall = busy_q && (((pend_rd_q != '0) && (|pend_hit)) || MduOpD);
        stall     = lw_stall || mdu_stall;
        StallF    = stall;
        StallD    = stall;
        FlushD    = PCSrcE;
        FlushE    = stall || PCSrcE;
    end

    // MDU latency counter: an issue (re)loads, otherwise count down to idle
    always_comb begin
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        if (MduStartE) begin
            cnt_d     = LAT;
            pend_rd_d = RdE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        busy_d = (cnt_d != '0);
    end

    // MDU state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pend_rd_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            busy_q    <= busy_d;
        end
    end

    assign MduBusy = busy_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] mdu_cnt_q, mdu_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mdu_cnt_d   = mdu_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (PCSrcE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (MduStartE && (mdu_cnt_q != 32'hFFFF_FFFF)) begin
            mdu_cnt_d = mdu_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mdu_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mdu_cnt_q   <= mdu_cnt_d;
        end
    end

    assign PerfStallCnt = stall_cnt_q;
    assign PerfFlushCnt = flush_cnt_q;
    assign PerfMduCnt   = mdu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (default parameters: 32-bit data, 5-bit
// register indices, two sources, MDU latency 4). Table of combinational
// vectors followed by hand-written multi-cycle MDU and reset sequences.
module tb_hazard_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;

    localparam logic [31:0] R0 = 32'h0000_0011;
    localparam logic [31:0] R1 = 32'h0000_0022;
    localparam logic [31:0] AM = 32'h0000_00AA;
    localparam logic [31:0] BW = 32'h0000_00BB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NS*AW-1:0] rs_d;
    logic             mdu_op_d;
    logic [NS*AW-1:0] rs_e;
    logic [AW-1:0]    rd_e;
    logic             load_e;
    logic             mdu_start_e;
    logic             pcsrc_e;
    logic [AW-1:0]    rd_m;
    logic             regwrite_m;
    logic [AW-1:0]    rd_w;
    logic             regwrite_w;
    logic [NS*DW-1:0] rd_data_e;
    logic [DW-1:0]    alu_m;
    logic [DW-1:0]    result_w;
    logic [NS*DW-1:0] src_e;
    logic [NS*2-1:0]  forward_e;
    logic             stall_f, stall_d, flush_d, flush_e, mdu_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]      perf_stall, perf_flush, perf_mdu;
`endif

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .RsD        (rs_d),
        .MduOpD     (mdu_op_d),
        .RsE        (rs_e),
        .RdE        (rd_e),
        .LoadE      (load_e),
        .MduStartE  (mdu_start_e),
        .PCSrcE     (pcsrc_e),
        .RdM        (rd_m),
        .RegWriteM  (regwrite_m),
        .RdW        (rd_w),
        .RegWriteW  (regwrite_w),
        .rdE        (rd_data_e),
        .ALUResultM (alu_m),
        .ResultW    (result_w),
        .SrcE       (src_e),
        .ForwardE   (forward_e),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .FlushD     (flush_d),
        .FlushE     (flush_e),
        .MduBusy    (mdu_busy)
`ifdef HAZARD_PERF_EN
        ,
        .PerfStallCnt (perf_stall),
        .PerfFlushCnt (perf_flush),
        .PerfMduCnt   (perf_mdu)
`endif
    );

    // ---------------- scoreboard / counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic e_stall, input logic e_fd,
                              input logic e_fe, input logic e_busy);
        check({tag, " StallF"},  {63'd0, stall_f},  {63'd0, e_stall});
        check({tag, " StallD"},  {63'd0, stall_d},  {63'd0, e_stall});
        check({tag, " FlushD"},  {63'd0, flush_d},  {63'd0, e_fd});
        check({tag, " FlushE"},  {63'd0, flush_e},  {63'd0, e_fe});
        check({tag, " MduBusy"}, {63'd0, mdu_busy}, {63'd0, e_busy});
    endtask

    function automatic logic [NS*AW-1:0] rs2(input logic [AW-1:0] s1, input logic [AW-1:0] s0);
        return {s1, s0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        rs_d        = '0;
        mdu_op_d    = 1'b0;
        rs_e        = '0;
        rd_e        = '0;
        load_e      = 1'b0;
        mdu_start_e = 1'b0;
        pcsrc_e     = 1'b0;
        rd_m        = '0;
        regwrite_m  = 1'b0;
        rd_w        = '0;
        regwrite_w  = 1'b0;
        rd_data_e   = {R1, R0};
        alu_m       = AM;
        result_w    = BW;
    endtask

    task automatic issue_mdu(input logic [AW-1:0] rd);
        @(negedge clk);
        idle();
        mdu_start_e = 1'b1;
        rd_e        = rd;
        @(posedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NS*AW-1:0] rs_d;
        logic             mdu_op_d;
        logic [NS*AW-1:0] rs_e;
        logic [AW-1:0]    rd_e;
        logic             load_e;
        logic             pcsrc_e;
        logic [AW-1:0]    rd_m;
        logic             rwm;
        logic [AW-1:0]    rd_w;
        logic             rww;
        logic [NS*DW-1:0] src_exp;
        logic [NS*2-1:0]  fwd_exp;
        logic             stall_exp;
        logic             fd_exp;
        logic             fe_exp;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int stall_cycles;
        int busy_bad;

        // MEM vs WB priority and x0 handling
        vecs[0]  = '{rs2(0,0), 0, rs2(3,5), 0, 0, 0, 5, 1, 5, 1, {R1, AM}, 4'b0010, 0, 0, 0};
        vecs[1]  = '{rs2(0,0), 0, rs2(3,5), 0, 0, 0, 0, 1, 5, 1, {R1, BW}, 4'b0001, 0, 0, 0};
        vecs[2]  = '{rs2(0,0), 0, rs2(3,5), 0, 0, 0, 5, 0, 5, 0, {R1, R0}, 4'b0000, 0, 0, 0};
        vecs[3]  = '{rs2(0,0), 0, rs2(5,5), 0, 0, 0, 5, 1, 0, 0, {AM, AM}, 4'b1010, 0, 0, 0};
        vecs[4]  = '{rs2(0,0), 0, rs2(0,0), 0, 0, 0, 0, 1, 0, 1, {R1, R0}, 4'b0000, 0, 0, 0};
        vecs[5]  = '{rs2(0,0), 0, rs2(9,4), 0, 0, 0, 4, 1, 9, 1, {BW, AM}, 4'b0110, 0, 0, 0};
        vecs[13] = '{rs2(0,0), 0, rs2(6,6), 0, 0, 0, 6, 0, 6, 1, {BW, BW}, 4'b0101, 0, 0, 0};
        // load-use detection
        vecs[6]  = '{rs2(7,2), 0, rs2(0,0), 7, 1, 0, 0, 0, 0, 0, {R1, R0}, 4'b0000, 1, 0, 1};
        vecs[7]  = '{rs2(0,0), 0, rs2(0,0), 0, 1, 0, 0, 0, 0, 0, {R1, R0}, 4'b0000, 0, 0, 0};
        vecs[8]  = '{rs2(3,2), 0, rs2(0,0), 7, 1, 0, 0, 0, 0, 0, {R1, R0}, 4'b0000, 0, 0, 0};
        vecs[9]  = '{rs2(7,7), 0, rs2(0,0), 7, 0, 0, 0, 0, 0, 0, {R1, R0}, 4'b0000, 0, 0, 0};
        // taken branch, alone and with a load-use stall
        vecs[10] = '{rs2(2,7), 0, rs2(0,0), 7, 1, 1, 0, 0, 0, 0, {R1, R0}, 4'b0000, 1, 1, 1};
        vecs[11] = '{rs2(0,0), 0, rs2(0,0), 0, 0, 1, 0, 0, 0, 0, {R1, R0}, 4'b0000, 0, 1, 1};
        // MDU op in decode with idle MDU
        vecs[12] = '{rs2(0,0), 1, rs2(0,0), 0, 0, 0, 0, 0, 0, 0, {R1, R0}, 4'b0000, 0, 0, 0};

        // ---- reset ----
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check_ctrl("reset", 0, 0, 0, 0);
        check("reset ForwardE", {60'd0, forward_e}, 64'd0);
        rst = 1'b0;

        // ---- table-driven combinational vectors ----
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle();
            rs_d       = vecs[i].rs_d;
            mdu_op_d   = vecs[i].mdu_op_d;
            rs_e       = vecs[i].rs_e;
            rd_e       = vecs[i].rd_e;
            load_e     = vecs[i].load_e;
            pcsrc_e    = vecs[i].pcsrc_e;
            rd_m       = vecs[i].rd_m;
            regwrite_m = vecs[i].rwm;
            rd_w       = vecs[i].rd_w;
            regwrite_w = vecs[i].rww;
            #2;
            check($sformatf("vec%0d SrcE", i), src_e, vecs[i].src_exp);
            check($sformatf("vec%0d ForwardE", i), {60'd0, forward_e}, {60'd0, vecs[i].fwd_exp});
            check_ctrl($sformatf("vec%0d", i), vecs[i].stall_exp, vecs[i].fd_exp,
                       vecs[i].fe_exp, 1'b0);
        end

        // ---- MDU issue: busy for four cycles, RAW on pending rd ----
        issue_mdu(5'd9);
        @(negedge clk);
        idle();
        rs_d = rs2(0, 9);
        #2;
        check_ctrl("mdu c1", 1, 0, 1, 1);
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            rs_d = (i == 3) ? rs2(3, 4) : rs2(9, 0);
            #2;
            check_ctrl($sformatf("mdu c%0d", i), (i != 3), 0, (i != 3), 1);
        end
        @(posedge clk);
        @(negedge clk);
        rs_d = rs2(0, 9);
        #2;
        check_ctrl("mdu c5", 0, 0, 0, 0);

        // ---- structural hazard: MDU op in decode waits for idle MDU ----
        issue_mdu(5'd0);
        @(negedge clk);
        idle();
        #2;
        check_ctrl("mdu x0 pend", 0, 0, 0, 1);
        stall_cycles = 0;
        busy_bad     = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            mdu_op_d = 1'b1;
            #2;
            if (!stall_d) break;
            stall_cycles++;
            if (mdu_busy !== 1'b1) busy_bad++;
        end
        check("struct stall cycles", 64'(stall_cycles), 64'd3);
        check("struct busy during stall", 64'(busy_bad), 64'd0);
        check("struct busy at release", {63'd0, mdu_busy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        idle();
        mdu_start_e = 1'b1;
        rd_e        = 5'd6;
        @(posedge clk);
        @(negedge clk);
        idle();
        rs_d = rs2(6, 0);
        #2;
        check_ctrl("second issue", 1, 0, 1, 1);
        repeat (5) @(posedge clk);

        // ---- back-to-back issue reloads counter and pending rd ----
        issue_mdu(5'd9);
        @(negedge clk);
        mdu_start_e = 1'b1;
        rd_e        = 5'd12;
        @(posedge clk);
        @(negedge clk);
        idle();
        rs_d = rs2(0, 9);
        #2;
        check_ctrl("reissue old rd", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            rs_d = rs2(0, 12);
            #2;
            check_ctrl($sformatf("reissue new rd %0d", i), 1, 0, 1, 1);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        check_ctrl("reissue done", 0, 0, 0, 0);

        // ---- reset in the middle of an MDU operation ----
        issue_mdu(5'd9);
        @(negedge clk);
        idle();
        rs_d = rs2(0, 9);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        load_e = 1'b1;
        rd_e   = 5'd7;
        rs_d   = rs2(7, 9);
        #2;
        check_ctrl("rst pre-edge", 1, 0, 1, 1);
        @(posedge clk);
        @(negedge clk);
        idle();
        rs_d = rs2(0, 9);
        #2;
        check_ctrl("rst cleared", 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
        check("perf stall cleared", {32'd0, perf_stall}, 64'd0);
        check("perf flush cleared", {32'd0, perf_flush}, 64'd0);
        check("perf mdu cleared",   {32'd0, perf_mdu},   64'd0);
`endif
        load_e = 1'b1;
        rd_e   = 5'd9;
        #2;
        check_ctrl("rst load-use", 1, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #2;
        check_ctrl("post rst idle", 0, 0, 0, 0);

        // ---- final report ----
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard unit for the pipelined RISC-V core. It is the successor to the per-operand forwarding mux.
- Forwards operand data for NUM_SRC execute-stage sources, with MEM-stage data taking priority over WB-stage data.
- Detects load-use hazards and generates the stall and flush controls for the F/D/E pipeline registers.
- Tracks one outstanding multi-cycle MDU (mul/div) operation with a latency counter and a pending-destination scoreboard.

Parameters:
- DATA_WIDTH, 32, operand/result width
- ADDR_WIDTH, 5, register index width
- NUM_SRC, 2, number of source operands per instruction (1..4)
- MDU_LATENCY, 4, cycles the MDU stays busy after issue (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RsD  in  NUM_SRC*ADDR_WIDTH  decode-stage source indices, packed, src0 in LSBs
- MduOpD  in  1  decode-stage instruction is an MDU op
- RsE  in  NUM_SRC*ADDR_WIDTH  execute-stage source indices
- RdE  in  ADDR_WIDTH  execute-stage destination
- LoadE  in  1  execute-stage instruction is a load
- MduStartE  in  1  execute-stage instruction issues to MDU
- PCSrcE  in  1  branch/jump taken in execute
- RdM  in  ADDR_WIDTH  MEM destination
- RegWriteM  in  1  MEM writes register file
- RdW  in  ADDR_WIDTH  WB destination
- RegWriteW  in  1  WB writes register file
- rdE  in  NUM_SRC*DATA_WIDTH  register-file operands latched into E
- ALUResultM  in  DATA_WIDTH  MEM-stage forward data
- ResultW  in  DATA_WIDTH  WB-stage forward data
- SrcE  out  NUM_SRC*DATA_WIDTH  forwarded operands
- ForwardE  out  NUM_SRC*2  per-source select: 00 reg, 01 WB, 10 MEM
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- MduBusy  out  1  MDU operation outstanding

Behaviour:
- Forwarding (combinational, per source i):
  - MEM forward when RegWriteM, RdM==RsE[i] and RdM!=0.
  - Otherwise WB forward when RegWriteW, RdW==RsE[i] and RdW!=0.
  - Otherwise 00.
  - MEM beats WB when both match. x0 is never forwarded.
- Load-use hazard (lwStall): LoadE and RdE!=0 and RdE equals any RsD[i].
- MDU state, registered:
  - State is a counter of clog2(MDU_LATENCY+1) bits, a pending register index PendRd, and MduBusy = (counter!=0).
  - On a clock edge with MduStartE=1: counter loads MDU_LATENCY and PendRd loads RdE.
  - Otherwise, while counter!=0, counter decrements by 1.
  - MduBusy is high for exactly MDU_LATENCY cycles after the issue edge.
  - The issuing instruction's own result is not forwarded by this block; it is written back by the MDU path.
- MDU hazard (mduStall): MduBusy, and either (PendRd!=0 and PendRd equals any RsD[i]) or MduOpD. MduOpD covers the structural hazard, since there is a single MDU.
- Stall = lwStall | mduStall.
- Outputs:
  - StallF = StallD = Stall.
  - FlushE = Stall | PCSrcE.
  - FlushD = PCSrcE.
- PCSrcE with Stall in the same cycle: flushes win for D/E. StallF/StallD remain asserted as computed, and the pipeline control gives flush priority.
- MduStartE while MduBusy cannot occur, because the structural stall prevents it. If it does occur, the counter and PendRd reload with the new values.
- Reset:
  - counter=0, PendRd=0, MduBusy=0 on the first edge with rst=1. This includes reset in the middle of an MDU operation.
  - While rst is high, all stall/flush outputs depend only on combinational inputs plus the cleared state.
- All outputs except MduBusy are combinational. MduBusy is registered.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three output ports:
  - PerfStallCnt (32), counts cycles with Stall=1.
  - PerfFlushCnt (32), counts cycles with PCSrcE=1.
  - PerfMduCnt (32), counts MduStartE edges.
- All three counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- RsE[0]=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1, ALUResultM=0xAA, ResultW=0xBB -> ForwardE[0]=10, SrcE[0]=0xAA. Same with RdM=0 -> forward from WB, 0xBB.
- LoadE=1, RdE=7, RsD[1]=7 -> StallF=StallD=FlushE=1 for that cycle. With RdE=0 -> no stall.
- MduStartE=1, RdE=9 at edge T (MDU_LATENCY=4) -> MduBusy=1 for T+1..T+4. RsD[0]=9 during that window -> Stall=1, cleared at T+5.
- MduOpD=1 while MduBusy -> Stall until MduBusy falls, and the second issue is never accepted early.
- PCSrcE=1 together with lwStall -> FlushD=1, FlushE=1.
- rst at T+2 of an MDU op -> MduBusy=0 next cycle and no stall on PendRd. With HAZARD_PERF_EN, counters read 0.
